// File: rtl/ride_pkg.sv
// Shared types for the ride safety FSM and its event logger.
// Heartbeat fault code FC_HEARTBEAT is only emitted when RIDE_LOG_HEARTBEAT_EN is defined.
package ride_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_WARNING  = 2'd1,
    ST_FAULT    = 2'd2,
    ST_SHUTDOWN = 2'd3
  } state_t;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_RESTRAINT = 3'd1;
  localparam logic [2:0] FC_BRAKE     = 3'd2;
  localparam logic [2:0] FC_VIBRATION = 3'd3;
  localparam logic [2:0] FC_QUEUE     = 3'd4;
  localparam logic [2:0] FC_HEARTBEAT = 3'd7;

  localparam int LOG_TS_W = 16;

  typedef struct packed {
    logic [LOG_TS_W-1:0] ts;
    state_t              prev_state;
    state_t              new_state;
    logic [2:0]          fault_code;
  } log_entry_t;

  typedef enum logic {
    S_LOG    = 1'b0,
    S_FROZEN = 1'b1
  } log_state_t;

  // Low 7 bits of a log entry; the timestamp is prepended by the logger.
  function automatic logic [6:0] pack_tail(input state_t prev_state,
                                           input state_t new_state,
                                           input logic [2:0] fault_code);
    return {prev_state, new_state, fault_code};
  endfunction

endpackage

// File: rtl/ride_log_fifo.sv
// Generic DEPTH x WIDTH first-word-fall-through FIFO; push and pop may coincide even when full.
module ride_log_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ride_event_logger.sv
// Timestamped black-box recorder of ride FSM state/fault changes; freezes after SHUTDOWN.
// Optional liveness entries on timestamp wrap: define RIDE_LOG_HEARTBEAT_EN.
module ride_event_logger
  import ride_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               state_in,
  input  logic [2:0]               fault_code_in,
  input  logic                     clear_i,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_W+6:0]          rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frozen,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int EW = TS_W + 7;
  localparam logic [TS_W-1:0]   TS_ONE   = TS_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  logic [TS_W-1:0] ts;
  state_t          last_state;
  logic [2:0]      last_fc;
  state_t          cur_state;
  log_state_t      st;
  log_state_t      st_nxt;
  logic            evt;
  logic            push_req;
  logic            pop;
  logic            full;
  logic            empty;
  logic            drop;
  logic [EW-1:0]   entry;

`ifdef RIDE_LOG_HEARTBEAT_EN
  logic            ts_wrapped;

  // High for exactly the cycle in which ts reads 0 after rolling over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_wrapped <= 1'b0;
    end else begin
      ts_wrapped <= (ts == '1);
    end
  end
`endif

  assign cur_state = state_t'(state_in);
  assign evt       = (cur_state != last_state) || (fault_code_in != last_fc);
  assign rd_valid  = !empty;
  assign pop       = rd_valid && rd_ready;
  assign drop      = push_req && full && !pop;
  assign frozen    = (st == S_FROZEN);

  always_comb begin
    st_nxt   = st;
    push_req = 1'b0;
    entry    = '0;
    case (st)
      S_LOG: begin
        if (evt) begin
          push_req = 1'b1;
          entry    = {ts, pack_tail(last_state, cur_state, fault_code_in)};
          // A dropped SHUTDOWN still freezes the logger.
          if (cur_state == ST_SHUTDOWN) begin
            st_nxt = S_FROZEN;
          end
        end
`ifdef RIDE_LOG_HEARTBEAT_EN
        else if (ts_wrapped) begin
          push_req = 1'b1;
          entry    = {ts, pack_tail(last_state, last_state, FC_HEARTBEAT)};
        end
`endif
      end
      S_FROZEN: begin
        if (clear_i) begin
          st_nxt = S_LOG;
        end
      end
      default: st_nxt = S_LOG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_LOG;
    end else begin
      st <= st_nxt;
    end
  end

  // Last-seen tracks the inputs every cycle, which also provides the resync on unfreeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      last_state <= ST_NORMAL;
      last_fc    <= FC_NONE;
    end else begin
      ts         <= ts + TS_ONE;
      last_state <= cur_state;
      last_fc    <= fault_code_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_i) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_ONE;
      end
    end
  end

  ride_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req && !drop),
    .din   (entry),
    .pop   (pop),
    .dout  (rd_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule
